// File: rtl/cpu_run_sequencer.sv
// Run/dump controller: enables the CPU until halt or a cycle limit, then streams registers 0..DUMP_REGS-1.
// Optional abort path is built when CPU_SEQ_ABORT_EN is defined.
module cpu_run_sequencer #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int DUMP_REGS = 12,
  parameter int CNT_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  max_cycles_i,
  input  logic              halt_i,
  output logic              cpu_run_o,
  output logic [ADDR_W-1:0] rf_raddr_o,
  input  logic [DATA_W-1:0] rf_rdata_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [ADDR_W-1:0] dump_idx_o,
  output logic [DATA_W-1:0] dump_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              timeout_o,
  output logic [CNT_W-1:0]  cycles_o
`ifdef CPU_SEQ_ABORT_EN
  ,
  input  logic              abort_i,
  output logic              aborted_o
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DUMP_RD, S_DUMP_TX, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DUMP_REGS - 1);

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    limit_reg, limit_next;
  logic [CNT_W-1:0]    cycles_reg, cycles_next;
  logic                timeout_reg, timeout_next;
  logic [ADDR_W-1:0]   idx_reg, idx_next;
  logic [ADDR_W-1:0]   dump_idx_reg, dump_idx_next;
  logic [DATA_W-1:0]   dump_data_reg, dump_data_next;
  logic                dump_valid_reg, dump_valid_next;
  logic                aborted_reg, aborted_next;
  logic                abort_req;
  logic                busy;
  logic [CNT_W-1:0]    cycles_inc;
  logic                limit_hit;

`ifdef CPU_SEQ_ABORT_EN
  assign abort_req = abort_i;
  assign aborted_o = aborted_reg;
`else
  assign abort_req = 1'b0;
`endif

  assign busy       = (state_reg == S_RUN) || (state_reg == S_DUMP_RD) || (state_reg == S_DUMP_TX);
  assign cycles_inc = cycles_reg + 1'b1;
  // Limit compares against the count including the current cycle, giving exactly max_cycles enabled cycles.
  assign limit_hit  = (limit_reg != '0) && (cycles_inc == limit_reg);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg      <= S_IDLE;
      limit_reg      <= '0;
      cycles_reg     <= '0;
      timeout_reg    <= 1'b0;
      idx_reg        <= '0;
      dump_idx_reg   <= '0;
      dump_data_reg  <= '0;
      dump_valid_reg <= 1'b0;
      aborted_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      limit_reg      <= limit_next;
      cycles_reg     <= cycles_next;
      timeout_reg    <= timeout_next;
      idx_reg        <= idx_next;
      dump_idx_reg   <= dump_idx_next;
      dump_data_reg  <= dump_data_next;
      dump_valid_reg <= dump_valid_next;
      aborted_reg    <= aborted_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    limit_next      = limit_reg;
    cycles_next     = cycles_reg;
    timeout_next    = timeout_reg;
    idx_next        = idx_reg;
    dump_idx_next   = dump_idx_reg;
    dump_data_next  = dump_data_reg;
    dump_valid_next = dump_valid_reg;
    aborted_next    = aborted_reg;

    unique case (state_reg)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_next   = S_RUN;
          limit_next   = max_cycles_i;
          cycles_next  = '0;
          timeout_next = 1'b0;
          idx_next     = '0;
          aborted_next = 1'b0;
        end
      end
      S_RUN: begin
        if (cycles_reg != '1) cycles_next = cycles_inc;
        if (halt_i) begin
          state_next = S_DUMP_RD;
        end else if (limit_hit) begin
          state_next   = S_DUMP_RD;
          timeout_next = 1'b1;
        end
      end
      S_DUMP_RD: begin
        dump_data_next  = rf_rdata_i;
        dump_idx_next   = idx_reg;
        dump_valid_next = 1'b1;
        state_next      = S_DUMP_TX;
      end
      S_DUMP_TX: begin
        if (dump_valid_reg && dump_ready_i) begin
          dump_valid_next = 1'b0;
          if (idx_reg == LAST_IDX) begin
            state_next = S_DONE;
          end else begin
            idx_next   = idx_reg + 1'b1;
            state_next = S_DUMP_RD;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase

    // Abort overrides every exit decided above, including a same-cycle halt or limit.
    if (abort_req && busy) begin
      state_next      = S_DONE;
      dump_valid_next = 1'b0;
      timeout_next    = timeout_reg;
      aborted_next    = 1'b1;
    end
  end

  assign cpu_run_o    = (state_reg == S_RUN);
  assign rf_raddr_o   = idx_reg;
  assign dump_valid_o = dump_valid_reg;
  assign dump_idx_o   = dump_idx_reg;
  assign dump_data_o  = dump_data_reg;
  assign busy_o       = busy;
  assign done_o       = (state_reg == S_DONE);
  assign timeout_o    = timeout_reg;
  assign cycles_o     = cycles_reg;

`ifndef CPU_SEQ_ABORT_EN
  logic unused_abort;
  assign unused_abort = aborted_reg;
`endif

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// Randomized bench for cpu_run_sequencer: each run is predicted from the max/halt rules and a model register file.
// Abort checks are compiled when CPU_SEQ_ABORT_EN is defined.
module tb_cpu_run_sequencer;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 5;
  localparam int DUMP_REGS = 12;
  localparam int CNT_W     = 8;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic [CNT_W-1:0]  max_cycles = '0;
  logic              halt = 1'b0;
  logic              cpu_run;
  logic [ADDR_W-1:0] rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic              dump_valid;
  logic              dump_ready = 1'b0;
  logic [ADDR_W-1:0] dump_idx;
  logic [DATA_W-1:0] dump_data;
  logic              busy;
  logic              done;
  logic              timeout;
  logic [CNT_W-1:0]  cycles;
`ifdef CPU_SEQ_ABORT_EN
  logic              abort = 1'b0;
  logic              aborted;
`endif

  logic [DATA_W-1:0] rf [1 << ADDR_W];
  assign rf_rdata = rf[rf_raddr];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cpu_run_sequencer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DUMP_REGS(DUMP_REGS), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .max_cycles_i(max_cycles), .halt_i(halt),
    .cpu_run_o(cpu_run), .rf_raddr_o(rf_raddr), .rf_rdata_i(rf_rdata),
    .dump_valid_o(dump_valid), .dump_ready_i(dump_ready), .dump_idx_o(dump_idx),
    .dump_data_o(dump_data), .busy_o(busy), .done_o(done), .timeout_o(timeout),
    .cycles_o(cycles)
`ifdef CPU_SEQ_ABORT_EN
    , .abort_i(abort), .aborted_o(aborted)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_run"}, 32'(cpu_run), 0);
    chk({tag, "_raddr"}, 32'(rf_raddr), 0);
    chk({tag, "_valid"}, 32'(dump_valid), 0);
    chk({tag, "_idx"}, 32'(dump_idx), 0);
    chk({tag, "_data"}, dump_data, 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_timeout"}, 32'(timeout), 0);
    chk({tag, "_cycles"}, 32'(cycles), 0);
  endtask

  // ready_mode: 0 = always ready, 1 = random, 2 = three stall cycles on idx 2
  task automatic run_one(input int max, input int halt_at, input int ready_mode, input bit noise);
    int run_len, exp_to, cnt, guard, words, stall_cnt;
    bit pend;
    logic [ADDR_W-1:0] p_idx;
    logic [DATA_W-1:0] p_data;

    if (halt_at > 0 && (max == 0 || halt_at <= max)) begin
      run_len = halt_at; exp_to = 0;
    end else begin
      run_len = max; exp_to = 1;
    end

    @(negedge clk);
    max_cycles = CNT_W'(max);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    max_cycles = CNT_W'($urandom);
    chk("start_done_clr", 32'(done), 0);
    chk("start_timeout_clr", 32'(timeout), 0);
`ifdef CPU_SEQ_ABORT_EN
    chk("start_aborted_clr", 32'(aborted), 0);
`endif

    cnt = 0; guard = 0;
    while (cpu_run && guard < 2000) begin
      cnt++; guard++;
      chk("run_cycles", 32'(cycles), sat(cnt - 1));
      halt  = (cnt == halt_at);
      start = noise & 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    halt = 1'b0; start = 1'b0;
    chk("run_len", cnt, run_len);

    words = 0; pend = 1'b0; guard = 0; stall_cnt = 0;
    while (!done && guard < 500) begin
      guard++;
      chk("dump_busy", 32'(busy), 1);
      chk("dump_run_off", 32'(cpu_run), 0);
      if (pend) begin
        chk("hold_valid", 32'(dump_valid), 1);
        chk("hold_idx", 32'(dump_idx), 32'(p_idx));
        chk("hold_data", dump_data, p_data);
      end
      if (!dump_valid) chk("rd_addr", 32'(rf_raddr), words);
      case (ready_mode)
        0: dump_ready = 1'b1;
        1: dump_ready = 1'($urandom_range(0, 1));
        default: begin
          dump_ready = 1'b1;
          if (dump_valid && dump_idx == 2 && stall_cnt < 3) begin
            dump_ready = 1'b0;
            stall_cnt++;
          end
        end
      endcase
      start = noise & 1'($urandom_range(0, 1));
      halt  = 1'($urandom_range(0, 1));
      if (dump_valid && dump_ready) begin
        chk("word_idx", 32'(dump_idx), words);
        if (words < DUMP_REGS) chk("word_data", dump_data, rf[words]);
        words++;
        pend = 1'b0;
      end else if (dump_valid) begin
        pend = 1'b1; p_idx = dump_idx; p_data = dump_data;
      end else begin
        pend = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0; halt = 1'b0; dump_ready = 1'b0;

    chk("done_reached", 32'(done), 1);
    chk("word_count", words, DUMP_REGS);
    chk("final_cycles", 32'(cycles), sat(run_len));
    chk("final_timeout", 32'(timeout), exp_to);
    chk("final_busy", 32'(busy), 0);
    chk("final_valid", 32'(dump_valid), 0);
    if (ready_mode == 2) chk("stall_seen", stall_cnt, 3);
    $display("run max=%0d halt_at=%0d ready_mode=%0d: cycles=%0d timeout=%0d words=%0d",
             max, halt_at, ready_mode, cycles, timeout, words);
  endtask

  initial begin
    int max, h;
    for (int i = 0; i < (1 << ADDR_W); i++) rf[i] = DATA_W'(i * 7);

    #1 rst_n = 1'b0;
    #2 chk_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("idle");

    run_one(5, 0, 0, 0);
    run_one(0, 3, 0, 0);
    run_one(4, 4, 0, 0);
    run_one(6, 0, 2, 1);
    run_one(0, 300, 1, 0);

    // Asynchronous reset in the middle of a dump
    @(negedge clk);
    max_cycles = CNT_W'(3); start = 1'b1;
    @(negedge clk);
    start = 1'b0; dump_ready = 1'b1;
    for (int g = 0; g < 40 && !(dump_valid && dump_idx == 4); g++) @(negedge clk);
    chk("pre_reset_valid", 32'(dump_valid), 1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midreset");
    dump_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_one(7, 0, 1, 1);

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < (1 << ADDR_W); i++) rf[i] = $urandom;
      max = $urandom_range(0, 20);
      h = (max == 0) ? $urandom_range(1, 20) : $urandom_range(0, 25);
      run_one(max, h, $urandom_range(0, 2), 1'b1);
    end

`ifdef CPU_SEQ_ABORT_EN
    @(negedge clk);
    max_cycles = CNT_W'(2); start = 1'b1;
    @(negedge clk);
    start = 1'b0; dump_ready = 1'b1;
    for (int g = 0; g < 60 && !(dump_valid && dump_idx == 5); g++) @(negedge clk);
    chk("abort_at_idx5", 32'(dump_idx), 5);
    dump_ready = 1'b0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_done", 32'(done), 1);
    chk("abort_flag", 32'(aborted), 1);
    chk("abort_valid", 32'(dump_valid), 0);
    chk("abort_busy", 32'(busy), 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_in_done_ignored", 32'(done), 1);
    chk("abort_flag_held", 32'(aborted), 1);
    $display("abort at idx 5: done=%0d aborted=%0d", done, aborted);
    run_one(3, 0, 0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
